// File: rtl/ddr2_spd_i2c_reader.sv
// Avalon-MM slave that fetches one byte from the DDR2 SPD EEPROM over I2C.
// Each bit slot is four ticks; SCL/SDA are open-drain via the *_oe outputs.
module ddr2_spd_i2c_reader #(
  parameter int         CLK_DIV  = 125,
  parameter logic [3:0] DEV_TYPE = 4'b1010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic [2:0] sa,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       irq
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] START    = 4'd1;
  localparam logic [3:0] TX_DEV_W = 4'd2;
  localparam logic [3:0] TX_OFF   = 4'd3;
  localparam logic [3:0] RSTART   = 4'd4;
  localparam logic [3:0] TX_DEV_R = 4'd5;
  localparam logic [3:0] RX       = 4'd6;
  localparam logic [3:0] NACK     = 4'd7;
  localparam logic [3:0] STOP     = 4'd8;

  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

  logic [3:0]  r_state;
  logic [1:0]  r_q;
  logic [3:0]  r_bit;
  logic [11:0] r_div;
  logic        r_busy;
  logic        r_done;
  logic        r_ack_err;
  logic        r_irq_en;
  logic [7:0]  r_data;
  logic [2:0]  r_sa;
  logic [7:0]  r_off;
  logic [7:0]  r_rx;
  logic        r_ack;
  logic        r_err;
  logic        r_scl_oe;
  logic        r_sda_oe;
  logic [1:0]  r_sync;

  logic        w_wr;
  logic        w_tick;
  logic [7:0]  w_tx_byte;
  logic        w_tx_bit;
  logic        w_sda;

  assign w_wr     = chipselect & ~write_n;
  assign w_tick   = r_busy && (r_div == DIV_LAST);
  assign w_tx_bit = w_tx_byte[3'd7 - r_bit[2:0]];
  assign w_sda    = r_sync[1];

  assign scl_oe = r_scl_oe;
  assign sda_oe = r_sda_oe;
  assign irq    = r_done & r_irq_en;

  always_comb begin
    readdata = 8'h00;
    case (address)
      2'd0:    readdata = {5'b0, r_busy, r_ack_err, r_done};
      2'd1:    readdata = r_data;
      2'd2:    readdata = {7'b0, r_irq_en};
      default: readdata = 8'h00;
    endcase
  end

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_state)
      TX_DEV_W: w_tx_byte = {DEV_TYPE, r_sa, 1'b0};
      TX_OFF:   w_tx_byte = r_off;
      TX_DEV_R: w_tx_byte = {DEV_TYPE, r_sa, 1'b1};
      default:  w_tx_byte = 8'h00;
    endcase
  end

  // The pad is asynchronous to clk; two flops before it is ever used.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= 2'b11;
    else          r_sync <= {r_sync[0], sda_in};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_q       <= 2'd0;
      r_bit     <= 4'd0;
      r_div     <= 12'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
      r_irq_en  <= 1'b0;
      r_data    <= 8'h00;
      r_sa      <= 3'd0;
      r_off     <= 8'h00;
      r_rx      <= 8'h00;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_scl_oe  <= 1'b0;
      r_sda_oe  <= 1'b0;
    end else begin
      if (w_wr && address == 2'd2) begin
        r_irq_en <= writedata[0];
        if (writedata[1]) begin
          r_done    <= 1'b0;
          r_ack_err <= 1'b0;
        end
      end

      if (w_wr && address == 2'd0 && !r_busy) begin
        r_busy    <= 1'b1;
        r_done    <= 1'b0;
        r_ack_err <= 1'b0;
        r_sa      <= sa;
        r_off     <= writedata;
        r_state   <= START;
        r_q       <= 2'd0;
        r_bit     <= 4'd0;
        r_err     <= 1'b0;
      end

      if (!r_busy || w_tick) r_div <= 12'd0;
      else                   r_div <= r_div + 12'd1;

      if (w_tick) begin
        r_q <= r_q + 2'd1;
        case (r_state)
          START: begin
            if (r_q == 2'd1) r_sda_oe <= 1'b1;
            if (r_q == 2'd3) begin
              r_scl_oe <= 1'b1;
              r_state  <= TX_DEV_W;
              r_bit    <= 4'd0;
            end
          end
          TX_DEV_W, TX_OFF, TX_DEV_R: begin
            case (r_q)
              2'd0: r_sda_oe <= (r_bit < 4'd8) ? ~w_tx_bit : 1'b0;
              2'd1: r_scl_oe <= 1'b0;
              2'd2: if (r_bit == 4'd8) r_ack <= w_sda;
              default: begin
                r_scl_oe <= 1'b1;
                if (r_bit == 4'd8) begin
                  r_bit <= 4'd0;
                  // A NACK on any addressing byte aborts straight to STOP
                  if (r_ack) begin
                    r_err   <= 1'b1;
                    r_state <= STOP;
                  end else if (r_state == TX_DEV_W) begin
                    r_state <= TX_OFF;
                  end else if (r_state == TX_OFF) begin
                    r_state <= RSTART;
                  end else begin
                    r_state <= RX;
                  end
                end else begin
                  r_bit <= r_bit + 4'd1;
                end
              end
            endcase
          end
          RSTART: begin
            case (r_q)
              2'd0:    r_sda_oe <= 1'b0;
              2'd1:    r_scl_oe <= 1'b0;
              2'd2:    r_sda_oe <= 1'b1;
              default: begin
                r_scl_oe <= 1'b1;
                r_state  <= TX_DEV_R;
              end
            endcase
          end
          RX: begin
            case (r_q)
              2'd0:    r_sda_oe <= 1'b0;
              2'd1:    r_scl_oe <= 1'b0;
              2'd2:    r_rx     <= {r_rx[6:0], w_sda};
              default: begin
                r_scl_oe <= 1'b1;
                if (r_bit == 4'd7) begin
                  r_bit   <= 4'd0;
                  r_state <= NACK;
                end else begin
                  r_bit <= r_bit + 4'd1;
                end
              end
            endcase
          end
          NACK: begin
            case (r_q)
              2'd0:    r_sda_oe <= 1'b0;
              2'd1:    r_scl_oe <= 1'b0;
              2'd2:    r_sda_oe <= 1'b0;
              default: begin
                r_scl_oe <= 1'b1;
                r_state  <= STOP;
              end
            endcase
          end
          STOP: begin
            case (r_q)
              2'd0:    r_sda_oe <= 1'b1;
              2'd1:    r_scl_oe <= 1'b0;
              2'd2:    r_sda_oe <= 1'b0;
              default: begin
                // Placed after the register-write clear so a same-cycle set wins
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_done    <= 1'b1;
                r_ack_err <= r_err;
                if (!r_err) r_data <= r_rx;
              end
            endcase
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr2_spd_i2c_reader.sv
// Directed bench: EEPROM bus model plus I2C monitor logging START/STOP/bytes.
module tb_ddr2_spd_i2c_reader;

  localparam int CLK_DIV = 2;
  localparam int EV_S    = 'h1000;
  localparam int EV_P    = 'h2000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] address = 2'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic [2:0] sa = 3'd0;
  logic       sda_in;
  logic       scl_oe;
  logic       sda_oe;
  logic       irq;

  logic       slave_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;
  logic       slave_pull = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int ev[$];

  always #5 clk = ~clk;

  assign sda_in = ~sda_oe & ~slave_pull;

  ddr2_spd_i2c_reader #(.CLK_DIV(CLK_DIV), .DEV_TYPE(4'b1010)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sa         (sa),
    .sda_in     (sda_in),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .irq        (irq)
  );

  // Bus monitor and EEPROM model, sampled away from the active edge
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [8:0] shreg = 9'd0;
  int         bitcnt = 0;
  int         byteidx = 0;
  logic       rd_mode = 1'b0;

  always @(negedge clk) begin
    logic cur_scl;
    logic cur_sda;
    cur_scl = ~scl_oe;
    cur_sda = ~sda_oe & ~slave_pull;
    if (!reset_n) begin
      bitcnt = 0;
      byteidx = 0;
      rd_mode = 1'b0;
      slave_pull = 1'b0;
      prev_scl = 1'b1;
      prev_sda = 1'b1;
    end else begin
      if (cur_scl && prev_scl && prev_sda && !cur_sda) begin
        ev.push_back(EV_S);
        bitcnt = 0;
        byteidx = 0;
        rd_mode = 1'b0;
      end else if (cur_scl && prev_scl && !prev_sda && cur_sda) begin
        ev.push_back(EV_P);
      end
      if (cur_scl && !prev_scl) begin
        shreg = {shreg[7:0], cur_sda};
        bitcnt++;
        if (bitcnt == 9) begin
          ev.push_back((int'(shreg[0]) << 8) | int'(shreg[8:1]));
          if (rd_mode) rd_mode = 1'b0;
          else if (byteidx == 0 && shreg[1] && !shreg[0]) rd_mode = 1'b1;
          byteidx++;
          bitcnt = 0;
        end
      end
      if (!cur_scl && prev_scl) begin
        if (!slave_en)                    slave_pull = 1'b0;
        else if (rd_mode && bitcnt < 8)   slave_pull = ~rd_byte[7 - bitcnt];
        else if (!rd_mode && bitcnt == 8) slave_pull = 1'b1;
        else                              slave_pull = 1'b0;
      end
      prev_scl = cur_scl;
      prev_sda = cur_sda;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("check %s: 0x%0h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n = 1'b1;
    $display("write addr=%0d data=0x%02h", a, d);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_done(output int cyc);
    logic [7:0] s;
    cyc = 0;
    bus_read(2'd0, s);
    while (!s[0] && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus_read(2'd0, s);
    end
    if (!s[0]) check("done_timeout", 32'(s), 32'h1);
  endtask

  task automatic check_events(input string tag, input int n, input int exp [8]);
    check({tag, "_ev_count"}, 32'(ev.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      int got;
      got = (i < ev.size()) ? ev[i] : -1;
      check($sformatf("%s_ev%0d", tag, i), 32'(got), 32'(exp[i]));
    end
  endtask

  initial begin
    logic [7:0] rd;
    int cyc;
    int e[8];

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd0, rd); check("rst_status", 32'(rd), 32'h00);
    bus_read(2'd1, rd); check("rst_data", 32'(rd), 32'h00);
    bus_read(2'd2, rd); check("rst_irq_en", 32'(rd), 32'h00);
    check("rst_lines", {30'd0, scl_oe, sda_oe}, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);

    // Good read of offset 0x02 returning 0x08
    slave_en = 1'b1;
    rd_byte = 8'h08;
    ev.delete();
    bus_write(2'd0, 8'h02);
    bus_read(2'd0, rd); check("good_busy", 32'(rd), 32'h04);
    wait_done(cyc);
    $display("good read done after %0d cycles", cyc);
    check("good_cycles", 32'(cyc >= 308 && cyc <= 316), 32'h1);
    bus_read(2'd0, rd); check("good_status", 32'(rd), 32'h01);
    bus_read(2'd1, rd); check("good_data", 32'(rd), 32'h08);
    check("good_irq_disabled", 32'(irq), 32'h0);
    e = '{EV_S, 'h0A0, 'h002, EV_S, 'h0A1, 'h108, EV_P, 0};
    check_events("good", 7, e);

    // Address NACK with sa=101 and no device present
    slave_en = 1'b0;
    sa = 3'b101;
    repeat (4) @(negedge clk);
    ev.delete();
    bus_write(2'd0, 8'h05);
    wait_done(cyc);
    $display("nack done after %0d cycles", cyc);
    check("nack_cycles", 32'(cyc >= 86 && cyc <= 90), 32'h1);
    bus_read(2'd0, rd); check("nack_status", 32'(rd), 32'h03);
    bus_read(2'd1, rd); check("nack_data_kept", 32'(rd), 32'h08);
    e = '{EV_S, 'h1AA, EV_P, 0, 0, 0, 0, 0};
    check_events("nack", 3, e);

    // Busy write ignored, sa latched, irq behaviour
    slave_en = 1'b1;
    sa = 3'b000;
    rd_byte = 8'h5C;
    bus_write(2'd2, 8'h01);
    repeat (4) @(negedge clk);
    ev.delete();
    bus_write(2'd0, 8'h33);
    repeat (40) @(negedge clk);
    sa = 3'b111;
    bus_write(2'd0, 8'h40);
    bus_read(2'd0, rd); check("busy_status", 32'(rd), 32'h04);
    wait_done(cyc);
    bus_read(2'd1, rd); check("latch_data", 32'(rd), 32'h5C);
    check("irq_set", 32'(irq), 32'h1);
    e = '{EV_S, 'h0A0, 'h033, EV_S, 'h0A1, 'h15C, EV_P, 0};
    check_events("latch", 7, e);
    repeat (10) @(negedge clk);
    bus_read(2'd0, rd); check("busy_write_not_queued", 32'(rd), 32'h01);

    rd_byte = 8'h77;
    ev.delete();
    bus_write(2'd0, 8'h10);
    bus_read(2'd0, rd); check("second_busy", 32'(rd), 32'h04);
    wait_done(cyc);
    bus_read(2'd1, rd); check("second_data", 32'(rd), 32'h77);
    e = '{EV_S, 'h0AE, 'h010, EV_S, 'h0AF, 'h177, EV_P, 0};
    check_events("second", 7, e);

    bus_write(2'd2, 8'h03);
    check("irq_cleared", 32'(irq), 32'h0);
    bus_read(2'd0, rd); check("clear_status", 32'(rd), 32'h00);
    bus_read(2'd2, rd); check("irq_en_read", 32'(rd), 32'h01);
    bus_read(2'd3, rd); check("addr3_read", 32'(rd), 32'h00);
    bus_write(2'd2, 8'h00);

    // Asynchronous reset in the middle of RX while SCL is held low
    sa = 3'b000;
    bus_write(2'd0, 8'h02);
    repeat (241) @(negedge clk);
    check("midrx_scl_low", 32'(scl_oe), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrx_rst_lines", {30'd0, scl_oe, sda_oe}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd0, rd); check("midrx_status", 32'(rd), 32'h00);
    bus_read(2'd1, rd); check("midrx_data", 32'(rd), 32'h00);
    check("midrx_irq", 32'(irq), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr2_spd_i2c_reader.md
Name: ddr2_spd_i2c_reader

Overview:
Avalon-MM slave that reads single bytes from the DDR2 DIMM SPD EEPROM over I2C, acting as bus master.
The 3-bit serial-address lines driven by the DDR2 I2C SA output PIO are an input here and form the EEPROM device address.
Software writes a byte offset, polls status or takes irq, then reads back the data byte.
Drives SCL/SDA open-drain through tri-state enables at the DE4 top level.

Parameters:
CLK_DIV, 125, clk cycles per quarter SCL period (tick); 50 MHz / (4*125) = 100 kHz SCL; legal range 2..4095
DEV_TYPE, 4'b1010, I2C device-type nibble for the SPD EEPROM

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
chipselect  in  1  Avalon slave select
write_n  in  1  active-low write strobe
writedata  in  8  write data
readdata  out  8  read data, combinational from address, zero wait states
sa  in  3  SPD serial address, from the SA PIO out_port plus board strap
sda_in  in  1  sampled SDA pad
scl_oe  out  1  1 = pull SCL low, 0 = release
sda_oe  out  1  1 = pull SDA low, 0 = release
irq  out  1  done & irq_en

Behaviour:
- Reset: clk is clk, reset reset_n, asynchronous, active-low. Reset forces scl_oe=0, sda_oe=0, irq=0, busy=0, done=0, ack_err=0, irq_en=0, data=0, FSM=IDLE, tick counter=0.
- Reset mid-transaction releases both lines immediately and abandons the transfer. No STOP is generated.
- Register map, reads (other addresses read 0):
  - 0: {5'b0, busy, ack_err, done}
  - 1: data[7:0]
  - 2: {7'b0, irq_en}
- Register map, writes:
  - 0: offset=writedata; starts a transaction when not busy. Ignored while busy.
  - 1: no effect.
  - 2: irq_en=wd[0]. wd[1]=1 clears done and ack_err.
- Start: write to address 0 sets busy=1 on the next edge, clears done and ack_err, and latches sa and offset. Later changes on sa do not affect the transaction.
- Tick counter: enabled only while busy; pulses every CLK_DIV clk cycles. All line changes happen on tick edges.
- Bit slot = 4 ticks:
  - Q0: set sda_oe with SCL low.
  - Q1: release SCL.
  - Q2: sample sda_in.
  - Q3: pull SCL low.
- Data is sent MSB first. ACK sampled 0 = ACK.
- States:
  - IDLE
  - START: SDA low while SCL released, then SCL low; 4 ticks.
  - TX_DEV_W: {DEV_TYPE, sa, 0} then ACK bit.
  - TX_OFF: offset then ACK bit.
  - RSTART: release SDA, release SCL, pull SDA low, pull SCL low; 4 ticks.
  - TX_DEV_R: {DEV_TYPE, sa, 1} then ACK bit.
  - RX: 8 bits, sda_oe=0, shift in at Q2.
  - NACK: master releases SDA for the 9th bit.
  - STOP: SDA low, release SCL, release SDA; 4 ticks.
  - IDLE
- Nominal transfer is 156 ticks. On the clk edge after the STOP completes: data<=shifted byte, done=1, busy=0.
- NACK on any of the three address/offset ACK bits: go to STOP directly, then set ack_err=1, done=1, busy=0. data is unchanged.
- Clear (addr 2, wd[1]) in the same cycle as the done set: the set wins.
- irq is registered-free: irq = done & irq_en.
- No clock stretching and no arbitration. SCL is never sampled.

Test Plan:
- Reset: assert reset_n=0 mid-RX → scl_oe=0 and sda_oe=0 in the same cycle; after release, status reads 0 and data reads 0x00.
- Good read: CLK_DIV=2, sa=3'b000, write offset 0x02; EEPROM model ACKs and returns 0x08 → bus shows bytes 0xA0, 0x02, repeated start, 0xA1, then master NACK and STOP. Status becomes 0x01 after 312±4 clk cycles; data reads 0x08.
- Address NACK: model absent (SDA released), sa=3'b101 → first byte on the bus is 0xAA. STOP follows right after the first ACK bit. Status reads 0x03; data keeps its previous value.
- Busy write: write offset 0x40 during a transfer, then 0x10 → the 0x40 write is ignored. A second transfer starts only on the 0x10 write after done.
- irq: irq_en=1, complete a read → irq=1; write addr 2 wd=0x03 → irq=0 and done=0 next cycle. With irq_en=0 and done=1, irq stays 0.
- sa latching: change sa from 000 to 111 mid-transfer → device byte after the repeated start is still 0xA1.
